mdu_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the execute stage. It schedules MULT/MULTU over a fixed-latency multiply and DIV/DIVU over a 32-iteration restoring divide, and stalls the pipeline while either is busy. It also serves MFHI/MFLO reads and MTHI/MTLO writes. It sits beside the ALU in execute, and its HI/LO read value is muxed into the execute result.

---
 rtl/mdu_ctrl_pkg.sv | 43 ++++
 rtl/mdu_ctrl_div_unit.sv | 66 ++++++
 rtl/mdu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared types for the multiply/divide unit of the execute stage:
//   word_t      - 32-bit architectural word
//   mduop_t     - MDU operation codes presented with req_op
//   mdu_state_t - sequencer states (IDLE, MUL, DIV, DONE)
// Helper functions for two's-complement sign handling and op classification.
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mduop_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    localparam int DIV_STEPS = 32;

    // Two's-complement negate when neg is set. The magnitude of 0x80000000
    // comes back as 0x80000000, which is the correct unsigned magnitude.
    function automatic word_t negate_if(input word_t v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_signed_op(input mduop_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_unit.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_div_unit
// Unsigned 32-bit restoring divider datapath, one quotient bit per step.
// The step result is presented combinationally so the controller can commit
// the final (32nd) step on the same edge that performs it.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   i_start      - load dividend/divisor magnitudes, clear remainder
//   i_step       - perform one restoring step this cycle
//   i_last       - this step is the final one
//   i_dividend   - dividend magnitude (sampled on i_start)
//   i_divisor    - divisor magnitude  (sampled on i_start)
//   o_done       - final step is being performed this cycle
//   o_quo        - quotient after this cycle's step
//   o_rem        - remainder after this cycle's step
// -----------------------------------------------------------------------------
module mdu_ctrl_div_unit
    import mdu_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_start,
    input  logic  i_step,
    input  logic  i_last,
    input  word_t i_dividend,
    input  word_t i_divisor,
    output logic  o_done,
    output word_t o_quo,
    output word_t o_rem
);

    word_t       r_rem;
    word_t       r_quo;
    word_t       r_dvsr;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift
    // in at the bottom. The remainder is always < divisor, so the 33-bit
    // shifted value minus the divisor is negative exactly when bit 32 is set.
    always_comb begin
        w_shift = {r_rem, r_quo[31]};
        w_diff  = w_shift - {1'b0, r_dvsr};
        w_ge    = ~w_diff[32];
        o_rem   = w_ge ? w_diff[31:0] : w_shift[31:0];
        o_quo   = {r_quo[30:0], w_ge};
        o_done  = i_step & i_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvsr <= '0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_dvsr <= i_divisor;
        end else if (i_step) begin
            r_rem  <= o_rem;
            r_quo  <= o_quo;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide sequencer and HI/LO owner for the execute stage.
// MULT/MULTU take 1+MUL_CYCLES stall cycles, DIV/DIVU take 33 (1 when the
// divisor is zero, which leaves HI/LO untouched). MFHI/MFLO read HI/LO
// combinationally; MTHI/MTLO write them from req_a when idle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (wins over flush)
//   flush       - abort any in-flight op; HI/LO are never written that cycle
//   req_valid   - execute-stage instruction is an MDU op
//   req_op      - operation code (mduop_t)
//   req_a/req_b - rs / rt operands, latched when a long op is accepted
//   rdata       - HI for MFHI, LO for MFLO, else 0
//   stall       - hold the execute stage this cycle (combinational)
//   hi_o/lo_o   - current HI/LO
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   req_valid,
    input  mduop_t req_op,
    input  word_t  req_a,
    input  word_t  req_b,
    output word_t  rdata,
    output logic   stall,
    output word_t  hi_o,
    output word_t  lo_o
);

    mdu_state_t r_state, w_state_nxt;
    logic [4:0] r_cnt, w_cnt_nxt;
    word_t      r_a, r_b;
    word_t      r_hi, r_lo;
    logic       r_mul_signed;
    logic       r_neg_q, r_neg_r;

    logic               w_op_signed;
    logic               w_mul_load, w_div_start, w_div_step;
    logic               w_wr_hi, w_wr_lo;
    word_t              w_hi_nxt, w_lo_nxt;
    logic signed [63:0] w_a_ext, w_b_ext;
    logic        [63:0] w_prod;
    logic               w_div_done;
    word_t              w_quo, w_rem;

    assign w_op_signed = is_signed_op(req_op);

    // Sign- or zero-extending to 64 bits lets one 64-bit multiplier produce
    // the correct low 64 bits for both MULT and MULTU.
    always_comb begin
        w_a_ext = r_mul_signed ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
        w_b_ext = r_mul_signed ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
        w_prod  = w_a_ext * w_b_ext;
    end

    mdu_ctrl_div_unit u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_step     (w_div_step),
        .i_last     (r_cnt == 5'd0),
        .i_dividend (negate_if(req_a, w_op_signed & req_a[31])),
        .i_divisor  (negate_if(req_b, w_op_signed & req_b[31])),
        .o_done     (w_div_done),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    // Next-state, stall and commit decode. flush suppresses every transition,
    // accept and HI/LO write, and drops stall for its cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        w_mul_load  = 1'b0;
        w_div_start = 1'b0;
        w_div_step  = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            MDU_MULT, MDU_MULTU: begin
                                stall       = 1'b1;
                                w_mul_load  = 1'b1;
                                w_state_nxt = S_MUL;
                                w_cnt_nxt   = 5'(MUL_CYCLES - 1);
                            end
                            MDU_DIV, MDU_DIVU: begin
                                stall       = 1'b1;
                                w_div_start = 1'b1;
                                if (req_b == 32'd0) begin
                                    w_state_nxt = S_DONE;
                                end else begin
                                    w_state_nxt = S_DIV;
                                    w_cnt_nxt   = 5'(DIV_STEPS - 1);
                                end
                            end
                            MDU_MTHI: begin
                                w_wr_hi  = 1'b1;
                                w_hi_nxt = req_a;
                            end
                            MDU_MTLO: begin
                                w_wr_lo  = 1'b1;
                                w_lo_nxt = req_a;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    stall = 1'b1;
                    if (r_cnt == 5'd0) begin
                        w_wr_hi     = 1'b1;
                        w_wr_lo     = 1'b1;
                        w_hi_nxt    = w_prod[63:32];
                        w_lo_nxt    = w_prod[31:0];
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    stall      = 1'b1;
                    w_div_step = 1'b1;
                    if (w_div_done) begin
                        w_wr_hi     = 1'b1;
                        w_wr_lo     = 1'b1;
                        w_lo_nxt    = negate_if(w_quo, r_neg_q);
                        w_hi_nxt    = negate_if(w_rem, r_neg_r);
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 5'd1;
                    end
                end
                default: begin
                    // DONE: the held instruction advances; requests are ignored.
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (req_valid && (req_op == MDU_MFHI)) rdata = r_hi;
        if (req_valid && (req_op == MDU_MFLO)) rdata = r_lo;
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_mul_signed <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_mul_load) begin
                r_a          <= req_a;
                r_b          <= req_b;
                r_mul_signed <= w_op_signed;
            end
            if (w_div_start) begin
                r_neg_q <= w_op_signed & (req_a[31] ^ req_b[31]);
                r_neg_r <= w_op_signed & req_a[31];
            end
            if (w_wr_hi) r_hi <= w_hi_nxt;
            if (w_wr_lo) r_lo <= w_lo_nxt;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   flush;
    logic   req_valid;
    mduop_t req_op;
    word_t  req_a, req_b;
    word_t  rdata, hi_o, lo_o;
    logic   stall;

    int checks = 0;
    int failures = 0;

    mdu_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rdata(rdata),
        .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a long op and advance until stall drops (DONE cycle); operands
    // are scrambled after acceptance. Returns the number of stall cycles.
    task automatic run_op(input mduop_t op, input word_t a, input word_t b, output int n);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; n = 0;
        #1;
        while (stall === 1'b1 && n < 100) begin
            tick();
            req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_F00D;
            n++;
            #1;
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_op = MDU_MFHI; req_a = '0; req_b = '0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = MDU_MFHI; req_a = '0; req_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_mult();
        int n;
        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_stall_cycles got=%0d exp=5", n); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mult_done_stall got=%b exp=0", stall); end
        checks++; if (hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", hi_o, 32'hFFFF_FFFF); end
        checks++; if (lo_o !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=%h", lo_o, 32'hFFFF_FFFA); end
        // req_valid still high with MULT through the DONE edge: must not restart
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL done_no_restart got=%b exp=0", stall); end
        repeat (6) tick();
        checks++; if (lo_o !== 32'hFFFF_FFFA) begin failures++; $display("FAIL done_no_restart_lo got=%h exp=%h", lo_o, 32'hFFFF_FFFA); end
    endtask

    task automatic test_multu();
        int n;
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_stall_cycles got=%0d exp=5", n); end
        checks++; if (hi_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=%h", hi_o, 32'hFFFF_FFFE); end
        checks++; if (lo_o !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", lo_o, 32'h1); end
        idle_cycle();
    endtask

    task automatic test_div();
        int n;
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 33) begin failures++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
        checks++; if (lo_o !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=%h", lo_o, 32'hFFFF_FFFD); end
        checks++; if (hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=%h", hi_o, 32'hFFFF_FFFF); end
        idle_cycle();
        run_op(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (lo_o !== 32'h7FFF_FFFC) begin failures++; $display("FAIL divu_lo got=%h exp=%h", lo_o, 32'h7FFF_FFFC); end
        checks++; if (hi_o !== 32'h0000_0001) begin failures++; $display("FAIL divu_hi got=%h exp=%h", hi_o, 32'h1); end
        idle_cycle();
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (lo_o !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=%h", lo_o, 32'h8000_0000); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=%h", hi_o, 32'h0); end
        idle_cycle();
        run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, n);
        checks++; if (lo_o !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negb_lo got=%h exp=%h", lo_o, 32'hFFFF_FFFD); end
        checks++; if (hi_o !== 32'h0000_0001) begin failures++; $display("FAIL div_negb_hi got=%h exp=%h", hi_o, 32'h1); end
        idle_cycle();
    endtask

    task automatic test_mt_mf();
        req_valid = 1'b1; req_op = MDU_MTLO; req_a = 32'h0000_ABCD;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mtlo_stall got=%b exp=0", stall); end
        tick();
        checks++; if (lo_o !== 32'h0000_ABCD) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", lo_o, 32'hABCD); end
        req_op = MDU_MTHI; req_a = 32'h11;
        tick();
        req_op = MDU_MTLO; req_a = 32'h22;
        tick();
        req_op = MDU_MFHI; req_a = '0;
        #1;
        checks++; if (rdata !== 32'h11) begin failures++; $display("FAIL mfhi_rdata got=%h exp=%h", rdata, 32'h11); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mfhi_idle_stall got=%b exp=0", stall); end
        req_op = MDU_MFLO;
        #1;
        checks++; if (rdata !== 32'h22) begin failures++; $display("FAIL mflo_rdata got=%h exp=%h", rdata, 32'h22); end
        idle_cycle();
    endtask

    task automatic test_div_zero();
        int n;
        run_op(MDU_DIV, 32'd5, 32'd0, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL divz_stall_cycles got=%0d exp=1", n); end
        idle_cycle();
        checks++; if (hi_o !== 32'h11) begin failures++; $display("FAIL divz_hi got=%h exp=%h", hi_o, 32'h11); end
        checks++; if (lo_o !== 32'h22) begin failures++; $display("FAIL divz_lo got=%h exp=%h", lo_o, 32'h22); end
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_op = MDU_DIVU; req_a = 32'd100; req_b = 32'd7;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_cycle_stall got=%b exp=0", stall); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_after_stall got=%b exp=0", stall); end
        repeat (40) tick();
        checks++; if (lo_o !== 32'h22) begin failures++; $display("FAIL flush_div_lo got=%h exp=%h", lo_o, 32'h22); end
        checks++; if (hi_o !== 32'h11) begin failures++; $display("FAIL flush_div_hi got=%h exp=%h", hi_o, 32'h11); end
        req_valid = 1'b1; req_op = MDU_MFLO;
        #1;
        checks++; if (rdata !== 32'h22) begin failures++; $display("FAIL flush_mflo got=%h exp=%h", rdata, 32'h22); end
        // flush on the final MUL cycle must block the commit
        req_op = MDU_MULT; req_a = 32'd3; req_b = 32'd5;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        repeat (3) tick();
        checks++; if (lo_o !== 32'h22) begin failures++; $display("FAIL flush_mul_lo got=%h exp=%h", lo_o, 32'h22); end
        // flush blocks an MTHI in IDLE
        req_valid = 1'b1; req_op = MDU_MTHI; req_a = 32'h99; flush = 1'b1;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (hi_o !== 32'h11) begin failures++; $display("FAIL flush_mthi got=%h exp=%h", hi_o, 32'h11); end
    endtask

    task automatic test_mf_during_mul();
        int n;
        req_valid = 1'b1; req_op = MDU_MULTU; req_a = 32'h10; req_b = 32'h2000_0000;
        tick();
        req_op = MDU_MFHI; req_a = '0; req_b = '0;
        n = 1;
        #1;
        while (stall === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 5) begin failures++; $display("FAIL mfhi_hold_cycles got=%0d exp=5", n); end
        checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL mfhi_done_rdata got=%h exp=%h", rdata, 32'h2); end
        idle_cycle();
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL mul_shift_lo got=%h exp=%h", lo_o, 32'h0); end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(MDU_DIVU, 32'd100, 32'd7, n);
        checks++; if (lo_o !== 32'd14) begin failures++; $display("FAIL b2b_divu_lo got=%h exp=%h", lo_o, 32'd14); end
        checks++; if (hi_o !== 32'd2) begin failures++; $display("FAIL b2b_divu_hi got=%h exp=%h", hi_o, 32'd2); end
        tick();
        run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, n);
        checks++; if (hi_o !== 32'h4000_0000) begin failures++; $display("FAIL b2b_mult_hi got=%h exp=%h", hi_o, 32'h4000_0000); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL b2b_mult_lo got=%h exp=%h", lo_o, 32'h0); end
        idle_cycle();
    endtask

    task automatic test_reset_midop();
        req_valid = 1'b1; req_op = MDU_DIV; req_a = 32'd50; req_b = 32'd3;
        repeat (5) tick();
        reset = 1'b1; req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=%h", hi_o, 32'h0); end
        repeat (40) tick();
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=%h", lo_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt_mf();
        test_div_zero();
        test_flush();
        test_mf_during_mul();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
